// File: rtl/eq_ui_controller.sv
// eq_ui_controller: pushbutton menu front end holding per-band signed EQ gains.
// Define EQ_UI_AUTOREPEAT_EN to add hold-to-repeat on the up/down keys.
module eq_ui_controller #(
    parameter int NUM_BANDS     = 6,
    parameter int GAIN_MAX      = 12,
    parameter int IDLE_TIMEOUT  = 500_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_key_mode,
    input  logic                   i_key_up,
    input  logic                   i_key_down,
    output logic [2:0]             o_state,
    output logic [2:0]             o_band,
    output logic [15:0]            o_gain,
    output logic [8*NUM_BANDS-1:0] o_gains,
    output logic                   o_gain_wr,
    output logic [2:0]             o_wr_band
);
    typedef enum logic [2:0] {S_HOME = 3'd1, S_BAND = 3'd2, S_GAIN = 3'd3} state_t;

    localparam logic [2:0]        LAST_BAND = 3'(NUM_BANDS);
    localparam logic signed [7:0] G_MAX     = 8'(GAIN_MAX);
    localparam logic signed [7:0] G_MIN     = -G_MAX;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_s1, r_s2, r_prev, r_arm;
    logic [1:0]        r_settle;
    logic [2:0]        r_band, r_wr_band;
    logic              r_gain_wr;
    logic [31:0]       r_idle;
    logic signed [7:0] r_gain [1:NUM_BANDS];
    logic [2:0]        w_ev;
    logic              w_up_req, w_dn_req, w_mode, w_up, w_dn, w_act, w_timeout;
    logic              w_gain_inc, w_gain_dec, w_wr;
    logic signed [7:0] w_cur;

    // Keys are only armed once seen released after reset, so a key held through reset is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_prev   <= '1;
            r_arm    <= '0;
            r_settle <= '0;
        end else begin
            r_s1     <= {i_key_mode, i_key_up, i_key_down};
            r_s2     <= r_s1;
            r_prev   <= r_s2;
            r_settle <= (r_settle == 2'd2) ? r_settle : r_settle + 2'd1;
            r_arm    <= r_arm | ((r_settle == 2'd2) ? r_s2 : 3'b000);
        end
    end

    assign w_ev = r_arm & r_prev & ~r_s2;

`ifdef EQ_UI_AUTOREPEAT_EN
    logic [31:0] r_rep_cnt;
    logic        r_rep_phase;
    logic [1:0]  w_held_keys;
    logic        w_held, w_rep;

    assign w_held_keys = r_arm[1:0] & ~r_s2[1:0];
    assign w_held      = (r_state != S_HOME) && (w_held_keys[1] ^ w_held_keys[0]);
    assign w_rep       = w_held && (r_rep_cnt == (r_rep_phase ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (!w_held || w_mode) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep) begin
            r_rep_cnt   <= 32'd1;
            r_rep_phase <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + 32'd1;
        end
    end

    assign w_up_req = w_ev[1] | (w_rep & w_held_keys[1]);
    assign w_dn_req = w_ev[0] | (w_rep & w_held_keys[0]);
`else
    assign w_up_req = w_ev[1];
    assign w_dn_req = w_ev[0];
`endif

    // Mode wins; simultaneous up and down cancel each other.
    assign w_mode = w_ev[2];
    assign w_up   = ~w_mode & w_up_req & ~w_dn_req;
    assign w_dn   = ~w_mode & w_dn_req & ~w_up_req;
    assign w_act  = |w_ev | w_up_req | w_dn_req;

    assign w_timeout = (IDLE_TIMEOUT != 0) && (r_state != S_HOME) && !w_act &&
                       (r_idle == 32'(IDLE_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode)
            w_state_nxt = (r_state == S_HOME) ? S_BAND : (r_state == S_BAND) ? S_GAIN : S_HOME;
        else if (w_timeout)
            w_state_nxt = S_HOME;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_HOME;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= (IDLE_TIMEOUT == 0 || w_act || r_state == S_HOME) ? 32'd0 : r_idle + 32'd1;
        end
    end

    assign w_cur      = r_gain[r_band];
    assign w_gain_inc = (r_state == S_GAIN) && w_up && (w_cur != G_MAX);
    assign w_gain_dec = (r_state == S_GAIN) && w_dn && (w_cur != G_MIN);
    assign w_wr       = w_gain_inc | w_gain_dec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_band    <= 3'd1;
            r_wr_band <= 3'd1;
            r_gain_wr <= 1'b0;
            for (int b = 1; b <= NUM_BANDS; b++) r_gain[b] <= '0;
        end else begin
            r_gain_wr <= w_wr;
            if (w_wr) begin
                r_gain[r_band] <= w_cur + (w_gain_inc ? 8'sd1 : -8'sd1);
                r_wr_band      <= r_band;
            end
            if (r_state == S_BAND && w_up)
                r_band <= (r_band == LAST_BAND) ? 3'd1 : r_band + 3'd1;
            else if (r_state == S_BAND && w_dn)
                r_band <= (r_band == 3'd1) ? LAST_BAND : r_band - 3'd1;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_pack
        assign o_gains[8*b +: 8] = r_gain[b+1];
    end

    assign o_state   = r_state;
    assign o_band    = r_band;
    assign o_gain    = {{8{w_cur[7]}}, w_cur};
    assign o_gain_wr = r_gain_wr;
    assign o_wr_band = r_wr_band;
endmodule
